// File: rtl/cv32e40p_irq_arbiter.sv
// Nesting-aware interrupt arbiter: pending, priority select, req/ack and level stack.
// Define CV32E40P_IRQ_EDGE_EN for per-line rising-edge triggering.
module cv32e40p_irq_arbiter #(
    parameter int NUM_IRQ    = 32,
    parameter int LVL_W      = 4,
    parameter int NEST_DEPTH = 4,
    localparam int ID_W      = $clog2(NUM_IRQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_IRQ-1:0]       irq_i,
    input  logic [NUM_IRQ-1:0]       irq_en_i,
    input  logic [NUM_IRQ-1:0]       irq_edge_i,
    input  logic [NUM_IRQ*LVL_W-1:0] irq_lvl_i,
    input  logic                     m_ie_i,
    input  logic                     irq_ack_i,
    input  logic                     irq_exit_i,
    output logic                     irq_req_o,
    output logic [ID_W-1:0]          irq_id_o,
    output logic [LVL_W-1:0]         irq_lvl_o,
    output logic                     irq_wu_o,
    output logic [NUM_IRQ-1:0]       mip_o,
    output logic [LVL_W-1:0]         cur_lvl_o,
    output logic                     nest_full_o
);

    localparam int CW = $clog2(NEST_DEPTH + 1);

    logic [NUM_IRQ-1:0] irq_q, irq_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] qual;
    logic               req_q, req_d;
    logic [ID_W-1:0]    id_q, id_d, sel_id;
    logic [LVL_W-1:0]   lvl_q, lvl_d, sel_lvl;
    logic [LVL_W-1:0]   cur_lvl;
    logic [LVL_W-1:0]   stk_q [NEST_DEPTH];
    logic [LVL_W-1:0]   stk_d [NEST_DEPTH];
    logic [CW-1:0]      cnt_q, cnt_d, cnt_pop;
    logic               ack_acc, held, nest_full;

    assign irq_d     = irq_i;
    assign ack_acc   = irq_ack_i & req_q;
    assign nest_full = (cnt_q == CW'(NEST_DEPTH));

    // Top of stack is the level of the running handler.
    always_comb begin
        cur_lvl = '0;
        for (int i = 0; i < NEST_DEPTH; i++) begin
            if (cnt_q == CW'(i + 1)) cur_lvl = stk_q[i];
        end
    end

    always_comb begin
        logic [LVL_W-1:0] lv;
        qual    = '0;
        sel_id  = '0;
        sel_lvl = '0;
        held    = 1'b0;
        for (int n = 0; n < NUM_IRQ; n++) begin
            lv = irq_lvl_i[n*LVL_W +: LVL_W];
            qual[n] = pend_q[n] & irq_en_i[n] & (lv > cur_lvl)
                    & m_ie_i & ~nest_full;
            // >= lets the higher id win a tie.
            if (qual[n] && lv >= sel_lvl) begin
                sel_id  = ID_W'(n);
                sel_lvl = lv;
            end
            if (qual[n] && id_q == ID_W'(n)) held = 1'b1;
        end
    end

    always_comb begin
        req_d = (|qual) & ~ack_acc & ~(req_q & ~held);
        id_d  = id_q;
        lvl_d = lvl_q;
        if (!req_q || !held) begin
            id_d  = sel_id;
            lvl_d = sel_lvl;
        end
    end

    // Exit pops before an ack in the same cycle pushes.
    always_comb begin
        stk_d   = stk_q;
        cnt_pop = cnt_q;
        if (irq_exit_i && cnt_q != '0) cnt_pop = cnt_q - CW'(1);
        cnt_d = cnt_pop;
        if (ack_acc && cnt_pop != CW'(NEST_DEPTH)) begin
            cnt_d = cnt_pop + CW'(1);
            for (int i = 0; i < NEST_DEPTH; i++) begin
                if (cnt_pop == CW'(i)) stk_d[i] = lvl_q;
            end
        end
    end

`ifdef CV32E40P_IRQ_EDGE_EN
    logic [NUM_IRQ-1:0] irq_q2_q, irq_q2_d;
    logic [NUM_IRQ-1:0] rise, clr;

    always_comb begin
        irq_q2_d = irq_q;
        rise     = irq_q & ~irq_q2_q;
        clr      = '0;
        pend_d   = '0;
        for (int n = 0; n < NUM_IRQ; n++) begin
            clr[n] = ack_acc && (id_q == ID_W'(n));
            // A fresh edge wins over the clear so it is not lost.
            pend_d[n] = irq_edge_i[n]
                      ? ((pend_q[n] & ~clr[n]) | rise[n])
                      : irq_q[n];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) irq_q2_q <= '0;
        else     irq_q2_q <= irq_q2_d;
    end
`else
    logic unused_edge;
    assign unused_edge = ^irq_edge_i;
    assign pend_d      = irq_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q  <= '0;
            pend_q <= '0;
            req_q  <= 1'b0;
            id_q   <= '0;
            lvl_q  <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < NEST_DEPTH; i++) stk_q[i] <= '0;
        end else begin
            irq_q  <= irq_d;
            pend_q <= pend_d;
            req_q  <= req_d;
            id_q   <= id_d;
            lvl_q  <= lvl_d;
            cnt_q  <= cnt_d;
            for (int i = 0; i < NEST_DEPTH; i++) stk_q[i] <= stk_d[i];
        end
    end

    assign irq_req_o   = req_q;
    assign irq_id_o    = id_q;
    assign irq_lvl_o   = lvl_q;
    assign irq_wu_o    = |(irq_i & irq_en_i);
    assign mip_o       = pend_q;
    assign cur_lvl_o   = cur_lvl;
    assign nest_full_o = nest_full;

endmodule

// File: tb/tb_cv32e40p_irq_arbiter.sv
// Bench for cv32e40p_irq_arbiter: vector table plus hand sequences, scoreboard checked.
// Edge sequences run only when CV32E40P_IRQ_EDGE_EN is defined.
module tb_cv32e40p_irq_arbiter;

    localparam int N  = 32;
    localparam int LW = 4;
    localparam int ND = 2;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  irq = '0;
    logic [N-1:0]  en = '1;
    logic [N-1:0]  edge_r = '0;
    logic [N*LW-1:0] lvl_r = '0;
    logic          mie = 1'b1;
    logic          ack = 1'b0;
    logic          ext = 1'b0;
    logic          req, wu, full;
    logic [IW-1:0] id;
    logic [LW-1:0] lvl, cur;
    logic [N-1:0]  mip;

    cv32e40p_irq_arbiter #(
        .NUM_IRQ(N), .LVL_W(LW), .NEST_DEPTH(ND)
    ) dut (
        .clk(clk), .rst(rst),
        .irq_i(irq), .irq_en_i(en), .irq_edge_i(edge_r),
        .irq_lvl_i(lvl_r), .m_ie_i(mie),
        .irq_ack_i(ack), .irq_exit_i(ext),
        .irq_req_o(req), .irq_id_o(id), .irq_lvl_o(lvl),
        .irq_wu_o(wu), .mip_o(mip),
        .cur_lvl_o(cur), .nest_full_o(full)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic          rst;
        logic [N-1:0]  irq;
        logic          ack;
        logic          ext;
        logic          req;
        logic [IW-1:0] id;
        logic [LW-1:0] lvl;
        logic [LW-1:0] cur;
        logic          full;
        logic          cm;
        logic [N-1:0]  mip;
        int            due;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [N-1:0] b(input int n);
        logic [N-1:0] one;
        one = 1;
        return one << n;
    endfunction

    function automatic vec_t mk(
        string nm, logic r, logic [N-1:0] i, logic a, logic e,
        logic rq, int di, int lv, int cu, logic fu,
        logic cm, logic [N-1:0] m);
        vec_t t;
        t.name = nm; t.rst = r; t.irq = i; t.ack = a; t.ext = e;
        t.req = rq; t.id = IW'(di); t.lvl = LW'(lv);
        t.cur = LW'(cu); t.full = fu; t.cm = cm; t.mip = m;
        t.due = 0;
        return t;
    endfunction

    function automatic void v(
        string nm, logic r, logic [N-1:0] i, logic a, logic e,
        logic rq, int di, int lv, int cu, logic fu,
        logic cm, logic [N-1:0] m);
        tbl.push_back(mk(nm, r, i, a, e, rq, di, lv, cu, fu, cm, m));
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_vec(vec_t t);
        chk({t.name, ".req"}, 64'(req), 64'(t.req));
        if (t.req) begin
            chk({t.name, ".id"}, 64'(id), 64'(t.id));
            chk({t.name, ".lvl"}, 64'(lvl), 64'(t.lvl));
        end
        chk({t.name, ".cur"}, 64'(cur), 64'(t.cur));
        chk({t.name, ".full"}, 64'(full), 64'(t.full));
        if (t.cm) chk({t.name, ".mip"}, 64'(mip), 64'(t.mip));
    endtask

    always @(negedge clk) begin : sb_chk
        vec_t t;
        while (sb.size() > 0 && sb[0].due == cyc) begin
            t = sb.pop_front();
            check_vec(t);
        end
    end

    task automatic apply(vec_t t);
        rst = t.rst; irq = t.irq; ack = t.ack; ext = t.ext;
        t.due = cyc + 1;
        sb.push_back(t);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        lvl_r[11*LW +: LW] = 3; lvl_r[3*LW +: LW]  = 7;
        lvl_r[5*LW +: LW]  = 2; lvl_r[20*LW +: LW] = 2;
        lvl_r[7*LW +: LW]  = 3; lvl_r[9*LW +: LW]  = 5;
        lvl_r[1*LW +: LW]  = 1; lvl_r[2*LW +: LW]  = 2;
        lvl_r[15*LW +: LW] = 15; lvl_r[4*LW +: LW] = 6;

        v("rst0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        v("rst1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        v("lv0", 0, b(11), 0, 0, 0, 0, 0, 0, 0, 1, 0);
        v("lv1", 0, b(11), 0, 0, 0, 0, 0, 0, 0, 1, b(11));
        v("lv2", 0, b(11), 0, 0, 1, 11, 3, 0, 0, 1, b(11));
        v("lv_ack", 0, 0, 1, 0, 0, 0, 0, 3, 0, 1, b(11));
        v("lv_exit", 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        v("lv_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        v("ex_empty", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        v("ack_noreq", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        v("p_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        v("p0", 0, b(3)|b(5)|b(20), 0, 0, 0, 0, 0, 0, 0, 1, 0);
        v("p1", 0, b(3)|b(5)|b(20), 0, 0, 0, 0, 0, 0, 0,
          1, b(3)|b(5)|b(20));
        v("p2", 0, b(3)|b(5)|b(20), 0, 0, 1, 3, 7, 0, 0, 0, 0);
        v("p_ack", 0, b(5)|b(20), 1, 0, 0, 0, 0, 7, 0,
          1, b(3)|b(5)|b(20));
        v("p4", 0, b(5)|b(20), 0, 0, 0, 0, 0, 7, 0, 1, b(5)|b(20));
        v("p_exit", 0, b(5)|b(20), 0, 1, 0, 0, 0, 0, 0, 0, 0);
        v("p_tie", 0, b(5)|b(20), 0, 0, 1, 20, 2, 0, 0, 0, 0);
        v("frz0", 0, b(3)|b(5)|b(20), 0, 0, 1, 20, 2, 0, 0, 0, 0);
        v("frz1", 0, b(3)|b(5)|b(20), 0, 0, 1, 20, 2, 0, 0, 0, 0);
        v("frz2", 0, b(3)|b(5)|b(20), 0, 0, 1, 20, 2, 0, 0, 0, 0);
        v("frz3", 0, b(3)|b(5)|b(20), 0, 0, 1, 20, 2, 0, 0, 0, 0);
        v("frz_ack", 0, 0, 1, 0, 0, 0, 0, 2, 0, 0, 0);

        v("n_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        v("n0", 0, b(11), 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v("n1", 0, b(11), 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v("n2", 0, b(11), 0, 0, 1, 11, 3, 0, 0, 0, 0);
        v("n_ack", 0, 0, 1, 0, 0, 0, 0, 3, 0, 0, 0);
        v("n_eq0", 0, b(7), 0, 0, 0, 0, 0, 3, 0, 0, 0);
        v("n_eq1", 0, b(7), 0, 0, 0, 0, 0, 3, 0, 0, 0);
        v("n_eq2", 0, b(7), 0, 0, 0, 0, 0, 3, 0, 1, b(7));
        v("n_hi0", 0, b(7)|b(9), 0, 0, 0, 0, 0, 3, 0, 0, 0);
        v("n_hi1", 0, b(7)|b(9), 0, 0, 0, 0, 0, 3, 0, 0, 0);
        v("n_hi2", 0, b(7)|b(9), 0, 0, 1, 9, 5, 3, 0, 0, 0);
        v("n_ack2", 0, b(7), 1, 0, 0, 0, 0, 5, 1, 0, 0);
        v("n_exit", 0, b(7), 0, 1, 0, 0, 0, 3, 0, 0, 0);
        v("n_idle", 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0);
        v("n_exit2", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

        v("f_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        v("f0", 0, b(1), 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v("f1", 0, b(1), 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v("f2", 0, b(1), 0, 0, 1, 1, 1, 0, 0, 0, 0);
        v("f_ack1", 0, b(2), 1, 0, 0, 0, 0, 1, 0, 0, 0);
        v("f4", 0, b(2), 0, 0, 0, 0, 0, 1, 0, 0, 0);
        v("f5", 0, b(2), 0, 0, 1, 2, 2, 1, 0, 0, 0);
        v("f_ack2", 0, b(15), 1, 0, 0, 0, 0, 2, 1, 0, 0);
        v("f_full0", 0, b(15), 0, 0, 0, 0, 0, 2, 1, 0, 0);
        v("f_full1", 0, b(15), 0, 0, 0, 0, 0, 2, 1, 1, b(15));
        v("f_full2", 0, b(15), 0, 0, 0, 0, 0, 2, 1, 0, 0);
        v("f_exit", 0, b(15), 0, 1, 0, 0, 0, 1, 0, 0, 0);
        v("f_back", 0, b(15), 0, 0, 1, 15, 15, 1, 0, 0, 0);
        v("f_ackex", 0, 0, 1, 1, 0, 0, 0, 15, 0, 0, 0);
        v("f_exit2", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        v("f_exit3", 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);

        v("r_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        v("r0", 0, b(11), 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v("r1", 0, b(11), 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v("r2", 0, b(11), 0, 0, 1, 11, 3, 0, 0, 0, 0);
        v("r_ack", 0, b(9), 1, 0, 0, 0, 0, 3, 0, 0, 0);
        v("r4", 0, b(9), 0, 0, 0, 0, 0, 3, 0, 0, 0);
        v("r5", 0, b(9), 0, 0, 1, 9, 5, 3, 0, 1, b(9));
        v("r_mid", 1, b(9), 0, 0, 0, 0, 0, 0, 0, 1, 0);
        v("r7", 0, b(9), 0, 0, 0, 0, 0, 0, 0, 1, 0);
        v("r8", 0, b(9), 0, 0, 0, 0, 0, 0, 0, 1, b(9));
        v("r9", 0, b(9), 0, 0, 1, 9, 5, 0, 0, 1, b(9));

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        apply(mk("g_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        mie = 1'b0;
        for (int k = 0; k < 3; k++)
            apply(mk("g_mie0", 0, b(11), 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("g_wu_on", 64'(wu), 64'd1);
        en[11] = 1'b0;
        #1 chk("g_wu_off", 64'(wu), 64'd0);
        en[11] = 1'b1;
        mie = 1'b1;
        apply(mk("g_mie1", 0, b(11), 0, 0, 1, 11, 3, 0, 0, 0, 0));
        en[11] = 1'b0;
        apply(mk("g_drop", 0, b(11), 0, 0, 0, 0, 0, 0, 0, 0, 0));
        en[11] = 1'b1;
        apply(mk("g_back", 0, b(11), 0, 0, 1, 11, 3, 0, 0, 0, 0));
        apply(mk("g_rst2", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

`ifdef CV32E40P_IRQ_EDGE_EN
        edge_r = b(4);
        apply(mk("e0", 0, b(4), 0, 0, 0, 0, 0, 0, 0, 1, 0));
        apply(mk("e1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, b(4)));
        apply(mk("e2", 0, 0, 0, 0, 1, 4, 6, 0, 0, 1, b(4)));
        apply(mk("e_hold", 0, 0, 0, 0, 1, 4, 6, 0, 0, 1, b(4)));
        apply(mk("e_ack", 0, 0, 1, 0, 0, 0, 0, 6, 0, 1, 0));
        apply(mk("e_exit", 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0));
        apply(mk("e_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        apply(mk("e7", 0, b(4), 0, 0, 0, 0, 0, 0, 0, 1, 0));
        apply(mk("e8", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, b(4)));
        apply(mk("e9", 0, 0, 0, 0, 1, 4, 6, 0, 0, 1, b(4)));
        apply(mk("e10", 0, b(4), 0, 0, 1, 4, 6, 0, 0, 1, b(4)));
        apply(mk("e_setwin", 0, 0, 1, 0, 0, 0, 0, 6, 0, 1, b(4)));
        apply(mk("e_exit2", 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, b(4)));
        apply(mk("e_again", 0, 0, 0, 0, 1, 4, 6, 0, 0, 0, 0));
        edge_r = '0;
`endif

        irq = '0; ack = 1'b0; ext = 1'b0;
        repeat (2) @(negedge clk);
        chk("sb_drain", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
